uart_tx_scheduler: RTL and testbench

Shares one 8N1 UART transmit line between NUM_CH byte producers, such as ADC sample channels and a status/debug source. The block generates its own baud-bit timing as a clock-enable counter off clk_50m, so no derived clock is used. It grants requesters round-robin, serialises the accepted byte, and reports which channel owns the line. It sits between the sample-packing logic and the board UART TX pin.

---
 rtl/uart_tx_scheduler_if.sv | 21 ++
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Request bundle between byte producers and the UART TX scheduler.
// One valid/ready pair and one byte lane per channel.
interface uart_tx_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART TX line between channels.
// Bit timing is a clock-enable counter on clk_50m; tx is registered.
module uart_tx_scheduler #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int NUM_CH   = 4,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic                      clk_50m,
    input  logic                      rst_n,
    uart_tx_scheduler_if.slave        req,
    output logic                      tx,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      frame_done
);
    localparam int IDW = $clog2(NUM_CH);
    localparam int CW  = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      byte_q, byte_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            tx_q, tx_d;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            bit_end;
    logic [NUM_CH-1:0] ready_c;

    // Round-robin search starting at ptr; first valid channel wins.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_id    = '0;
        j         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!win_found && req.req_valid[j]) begin
                win_found = 1'b1;
                win_id    = IDW'(j);
            end
        end
    end

    assign bit_end = (cnt_q == CW'(BAUD_DIV - 1));

    // Frame sequencing, bit timing and accept strobe generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        tx_d       = tx_q;
        ready_c    = '0;
        frame_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (win_found && rst_n) begin
                    ready_c = NUM_CH'(1) << win_id;
                    byte_d  = req.req_data[8*int'(win_id) +: 8];
                    grant_d = win_id;
                    ptr_d   = (win_id == IDW'(NUM_CH - 1)) ? '0 : win_id + 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    tx_d    = byte_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = byte_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset forces the line idle immediately.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            byte_q  <= 8'h00;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    assign req.req_ready = ready_c;
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler against a frame-timer model.
// Also measures one frame of a default-parameter instance.
module tb_uart_tx_scheduler;
    localparam int D   = 10;
    localparam int NCH = 4;
    localparam int DD  = 5208;

    logic clk_50m = 1'b0;
    logic rst_n;
    always #5 clk_50m = ~clk_50m;

    uart_tx_scheduler_if #(.NUM_CH(NCH)) rif ();
    uart_tx_scheduler_if #(.NUM_CH(NCH)) dif ();

    logic       tx, busy, frame_done;
    logic [1:0] grant_id;
    logic       d_tx, d_busy, d_fd;
    logic [1:0] d_gid;

    uart_tx_scheduler #(
        .CLK_FREQ(1000),
        .BAUD(100),
        .NUM_CH(NCH)
    ) dut (
        .clk_50m(clk_50m),
        .rst_n(rst_n),
        .req(rif),
        .tx(tx),
        .busy(busy),
        .grant_id(grant_id),
        .frame_done(frame_done)
    );

    uart_tx_scheduler #(
        .NUM_CH(NCH)
    ) dut_dflt (
        .clk_50m(clk_50m),
        .rst_n(rst_n),
        .req(dif),
        .tx(d_tx),
        .busy(d_busy),
        .grant_id(d_gid),
        .frame_done(d_fd)
    );

    int total = 0;
    int bad   = 0;

    bit         mbusy;
    int         t;
    logic [7:0] mbyte;
    int         mgrant;
    int         mptr;
    int         grants[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // Expected line level t clocks after the accept edge.
    function automatic logic exp_tx(input logic [7:0] b, input int tt);
        int s;
        s = tt / D;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mbusy  = 1'b0;
        t      = 0;
        mbyte  = 8'h00;
        mgrant = 0;
        mptr   = 0;
    endtask

    // One clock: check outputs, drive inputs, check ready, advance model.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d);
        int w;
        check("tx", tx, mbusy ? exp_tx(mbyte, t) : 1'b1);
        check("busy", busy, mbusy);
        check("grant_id", grant_id, mgrant);
        check("frame_done", frame_done, (mbusy && t == 10*D-1) ? 1 : 0);
        rif.req_valid = v;
        rif.req_data  = d;
        #1;
        w = mbusy ? -1 : rr_pick(v, mptr);
        check("req_ready", rif.req_ready, (w < 0) ? 0 : (1 << w));
        if (mbusy) begin
            t++;
            if (t == 10*D) mbusy = 1'b0;
        end else if (w >= 0) begin
            mbusy  = 1'b1;
            t      = 0;
            mbyte  = d[8*w +: 8];
            mgrant = w;
            mptr   = (w + 1) % NCH;
            grants.push_back(w);
        end
        @(negedge clk_50m);
    endtask

    task automatic run(input logic [3:0] v, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) cycle(v, d);
    endtask

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        int          n, n_rise, n_fd, n_idle, guard;

        rst_n         = 1'b0;
        rif.req_valid = '0;
        rif.req_data  = '0;
        dif.req_valid = '0;
        dif.req_data  = '0;
        model_reset();
        @(negedge clk_50m);
        @(negedge clk_50m);
        rif.req_valid = 4'hF;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_gid", grant_id, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ready", rif.req_ready, 0);
        rif.req_valid = '0;
        @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);

        // single byte on ch2
        grants.delete();
        cycle(4'b0100, 32'h00A5_0000);
        run(4'b0000, 32'h0, 105);
        check("single_gid", grant_id, 2);
        check("single_cnt", grants.size(), 1);

        // pointer fairness: ch0 alone, then ch0+ch3
        grants.delete();
        cycle(4'b0001, 32'h0000_0033);
        run(4'b0000, 32'h0, 105);
        run(4'b1001, 32'hC300_003C, 202);
        run(4'b0000, 32'h0, 105);
        check("fair_cnt", grants.size(), 3);
        if (grants.size() == 3) begin
            check("fair_g0", grants[0], 0);
            check("fair_g1", grants[1], 3);
            check("fair_g2", grants[2], 0);
        end

        // withdrawn request while busy
        grants.delete();
        cycle(4'b1000, 32'h5A00_0000);
        cycle(4'b0010, 32'h0000_7700);
        run(4'b0000, 32'h0, 110);
        check("wd_cnt", grants.size(), 1);
        if (grants.size() == 1) check("wd_ch", grants[0], 3);

        // reset during DATA bit 4 (byte bit4 is 0 so tx is low)
        cycle(4'b0100, 32'h00EF_0000);
        guard = 0;
        while (!(mbusy && t == 5*D + 3) && guard < 200) begin
            cycle(4'b0000, 32'h0);
            guard++;
        end
        check("mid_reach", guard < 200, 1);
        check("mid_pre_tx", tx, 0);
        #2;
        rst_n         = 1'b0;
        rif.req_valid = 4'hF;
        #1;
        check("mid_tx", tx, 1);
        check("mid_busy", busy, 0);
        check("mid_gid", grant_id, 0);
        check("mid_fd", frame_done, 0);
        check("mid_ready", rif.req_ready, 0);
        model_reset();
        @(negedge clk_50m);
        rst_n = 1'b1;

        // contention after reset: all channels valid
        grants.delete();
        run(4'hF, 32'h1312_1110, 500);
        run(4'b0000, 32'h0, 105);
        check("cont_cnt", grants.size(), 5);
        for (int i = 0; i < grants.size() && i < 5; i++) begin
            check("cont_order", grants[i], i % NCH);
        end

        // random traffic
        rv = '0;
        rd = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rv = 4'($urandom_range(0, 15));
                rd = $urandom;
            end
            cycle(rv, rd);
        end
        run(4'b0000, 32'h0, 105);

        // default parameters: one frame, 5208 clocks per bit
        dif.req_valid = 4'b0001;
        dif.req_data  = 32'h0000_0055;
        #1;
        check("dflt_ready", dif.req_ready, 1);
        @(negedge clk_50m);
        dif.req_valid = '0;
        n_rise = -1;
        n_fd   = -1;
        n_idle = -1;
        n      = 0;
        check("dflt_start", d_tx, 0);
        while (n_idle < 0 && n < 60000) begin
            @(negedge clk_50m);
            n++;
            if (n_rise < 0 && d_tx) n_rise = n;
            if (n_fd < 0 && d_fd) n_fd = n;
            if (!d_busy) n_idle = n;
        end
        check("dflt_bit", n_rise, DD);
        check("dflt_fd", n_fd, 10*DD - 1);
        check("dflt_frame", n_idle, 10*DD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
